// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, status bit layout, FSM encoding.
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_WRDI = 8'h04;
    localparam logic [7:0] CMD_RDSR = 8'h05;

    localparam int WIP = 0;
    localparam int WEL = 1;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        READ_DATA,
        PROG_DATA,
        STATUS,
        IGNORE
    } state_e;

    function automatic logic [7:0] status_byte(input logic wel, input logic wip);
        logic [7:0] s;
        s      = 8'h00;
        s[WEL] = wel;
        s[WIP] = wip;
        return s;
    endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// Single-port byte RAM with 1-cycle read latency and an AND-only (flash program) write.
module spi_flash_mem
    import spi_flash_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [7:0]           wdata_i,
    output logic [7:0]           rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    // Cells hold the complement, so a zero power-up image reads back as erased 8'hFF.
    logic [7:0] cell_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            cell_q[addr_i] <= cell_q[addr_i] | ~wdata_i;
        end
        rdata_q <= ~cell_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI Mode 0 serial-flash emulator: READ, PAGE PROGRAM, WREN, WRDI, RDSR with modelled busy time.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int ADDR_BITS    = 12,
    parameter int PAGE_BITS    = 8,
    parameter int WRITE_CYCLES = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic i_SPI_CLK,
    input  logic i_SPI_CS,
    input  logic i_SPI_MOSI,
    output logic o_SPI_MISO,
    output logic o_SPI_MISO_OE,
    output logic o_busy
);

    localparam int BW = $clog2(WRITE_CYCLES + 1);
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'((1 << PAGE_BITS) - 1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q, cs_prev_q;
    logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall;

    state_e               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d, shift_in;
    logic [7:0]           tx_q, tx_d, tx_cur;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 is_read_q, is_read_d;
    logic                 wel_q, wel_d, wip_q, wip_d;
    logic                 wrote_q, wrote_d;
    logic                 rd_load_q, rd_load_d;
    logic                 miso_q, miso_d, oe_q, oe_d;
    logic [BW-1:0]        busy_q, busy_d;
    logic                 byte_done;

    logic                 mem_we;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], i_SPI_CLK};
            cs_sync_q   <= {cs_sync_q[0], i_SPI_CS};
            mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
            sck_prev_q  <= sck_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    assign sck_s    = sck_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;
    assign shift_in = {shift_q[6:0], mosi_s};
    assign tx_cur   = rd_load_q ? mem_rdata : tx_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_cur;
        addr_d    = addr_q;
        is_read_d = is_read_q;
        wel_d     = wel_q;
        wip_d     = wip_q;
        wrote_d   = wrote_q;
        rd_load_d = 1'b0;
        miso_d    = miso_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        byte_done = 1'b0;
        mem_we    = 1'b0;

        if (busy_q != '0) begin
            busy_d = busy_q - 1'b1;
            if (busy_q == BW'(1)) wip_d = 1'b0;
        end

        if (state_q != IDLE && sck_rise) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            case (state_q)
                CMD: begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        state_d   = IGNORE;
                        if (!wip_q || shift_in == CMD_RDSR) begin
                            case (shift_in)
                                CMD_READ: begin
                                    state_d   = ADDR;
                                    is_read_d = 1'b1;
                                end
                                CMD_PP: begin
                                    state_d   = wel_q ? ADDR : IGNORE;
                                    is_read_d = 1'b0;
                                end
                                CMD_WREN: wel_d = 1'b1;
                                CMD_WRDI: wel_d = 1'b0;
                                CMD_RDSR: begin
                                    state_d = STATUS;
                                    tx_d    = status_byte(wel_q, wip_q);
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    addr_d = {addr_q[ADDR_BITS-2:0], mosi_s};
                    if (bit_cnt_q == 5'd23) begin
                        bit_cnt_d = 5'd0;
                        state_d   = is_read_q ? READ_DATA : PROG_DATA;
                        rd_load_d = is_read_q;
                    end
                end
                READ_DATA: begin
                    // Prefetch on the bit-0 rise so the next byte is ready for the following fall.
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        addr_d    = addr_q + ADDR_ONE;
                        rd_load_d = 1'b1;
                    end
                end
                STATUS: begin
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        tx_d      = status_byte(wel_q, wip_q);
                    end
                end
                PROG_DATA: begin
                    shift_d = shift_in;
                    if (bit_cnt_q == 5'd7) begin
                        bit_cnt_d = 5'd0;
                        mem_we    = 1'b1;
                        byte_done = 1'b1;
                        wrote_d   = 1'b1;
                        addr_d    = (addr_q & ~PAGE_MASK) | ((addr_q + ADDR_ONE) & PAGE_MASK);
                    end
                end
                default: ;
            endcase
        end

        if (sck_fall && (state_q == READ_DATA || state_q == STATUS)) begin
            miso_d = tx_cur[7];
            tx_d   = {tx_cur[6:0], 1'b0};
            oe_d   = 1'b1;
        end

        // SCK work above is already folded in, so a byte finished this cycle still commits.
        if (cs_s) begin
            if (state_q == PROG_DATA && (wrote_q || byte_done)) begin
                wip_d  = 1'b1;
                wel_d  = 1'b0;
                busy_d = BW'(WRITE_CYCLES);
            end
            state_d   = IDLE;
            bit_cnt_d = 5'd0;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            wrote_d   = 1'b0;
            rd_load_d = 1'b0;
        end else if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = 5'd0;
            oe_d      = 1'b0;
            wrote_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= 5'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            addr_q    <= '0;
            is_read_q <= 1'b0;
            wel_q     <= 1'b0;
            wip_q     <= 1'b0;
            wrote_q   <= 1'b0;
            rd_load_q <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            is_read_q <= is_read_d;
            wel_q     <= wel_d;
            wip_q     <= wip_d;
            wrote_q   <= wrote_d;
            rd_load_q <= rd_load_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
        end
    end

    assign mem_addr = mem_we ? addr_q : addr_d;

    spi_flash_mem #(
        .ADDR_BITS(ADDR_BITS)
    ) u_mem (
        .clk_i  (clk),
        .we_i   (mem_we),
        .addr_i (mem_addr),
        .wdata_i(shift_in),
        .rdata_o(mem_rdata)
    );

    assign o_SPI_MISO    = miso_q;
    assign o_SPI_MISO_OE = oe_q;
    assign o_busy        = wip_q;

endmodule
